serial_add_seq: RTL and testbench

- Bit-serial add/subtract sequencer that time-shares one 1-bit full-adder cell (ADDER) across a WIDTH-bit operation.
- Processes one bit per clock, LSB first, and keeps the carry in a flip-flop between bits.
- Sits beside the ALU as a low-area arithmetic path; a control unit drives it with a START/DONE handshake.

---
 rtl/serial_add_seq.sv | 100 ++++++++++
 tb/tb_serial_add_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one full-adder cell reused over WIDTH clocks, LSB first.
// A result and its flags appear together WIDTH cycles after the accept edge.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_y,
    output logic             o_c_out,
    output logic             o_v
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [WIDTH-1:0]  r_sr;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_y;
    logic              r_cout;
    logic              r_v;

    logic w_accept;
    logic w_run;
    logic w_last;
    logic w_sum;
    logic w_cy;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = i_start && !w_run;
    assign w_last   = w_run && (r_cnt == LAST);

    // The single shared full-adder cell.
    assign w_sum = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_cy  = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_FIN;
            S_FIN:   w_next = i_start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B up front and seed the carry.
            r_sa    <= i_a;
            r_sb    <= i_b ^ {WIDTH{i_sub}};
            r_carry <= i_sub;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else if (w_run) begin
            r_sr    <= {w_sum, r_sr[WIDTH-1:1]};
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_carry <= w_cy;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // r_carry here is the carry into the MSB.
                r_y    <= {w_sum, r_sr[WIDTH-1:1]};
                r_cout <= w_cy;
                r_v    <= r_carry ^ w_cy;
            end
        end
    end

    assign o_busy  = w_run;
    assign o_done  = (r_state == S_FIN);
    assign o_y     = r_y;
    assign o_c_out = r_cout;
    assign o_v     = r_v;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq against an arithmetic reference model.
module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         cout;
    logic         v;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_y = '0;

    serial_add_seq #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_sub   (sub),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_y     (y),
        .o_c_out (cout),
        .o_v     (v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic and sign rules for overflow.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic msub,
                                  output logic [7:0] ry, output logic rc, output logic rv);
        int s;
        if (!msub) begin
            s  = int'(ma) + int'(mb);
            ry = s[7:0];
            rc = (s > 255);
            rv = (ma[7] == mb[7]) && (ry[7] != ma[7]);
        end else begin
            s  = int'(ma) - int'(mb);
            ry = s[7:0];
            rc = (ma >= mb);
            rv = (ma[7] != mb[7]) && (ry[7] != ma[7]);
        end
    endfunction

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tsub, input int glitch);
        logic [7:0] ey;
        logic       ec;
        logic       ev;
        int         cnt;
        logic       mid_ok;
        model(ta, tb_, tsub, ey, ec, ev);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; sub = tsub;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        cnt = 1;
        mid_ok = 1'b1;
        while (!done && cnt < 30) begin
            if (busy !== 1'b1 || y !== prev_y) mid_ok = 1'b0;
            if (cnt == glitch) begin start = 1'b1; a = 8'hAA; end
            if (cnt == glitch + 1) start = 1'b0;
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check({tag, ":latency"}, cnt, 9);
        check({tag, ":run_busy_hold"}, mid_ok, 1);
        check({tag, ":y"}, y, ey);
        check({tag, ":c_out"}, cout, ec);
        check({tag, ":v"}, v, ev);
        check({tag, ":busy_at_done"}, busy, 0);
        prev_y = ey;
        @(negedge clk);
        check({tag, ":done_pulse"}, done, 0);
        check({tag, ":y_hold"}, y, ey);
    endtask

    initial begin
        int   cnt;
        logic busy_ok;
        logic saw_done;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:y", y, 0);
        check("reset:c_out", cout, 0);
        check("reset:v", v, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 0);
        do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 0);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 0);
        do_op("sub_equal", 8'h5A, 8'h5A, 1'b1, 0);
        do_op("start_in_run_ignored", 8'h10, 8'h20, 1'b0, 3);
        check("ignored:y_value", y, 8'h30);

        // START held high: back-to-back operations every 9 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
        @(negedge clk);
        cnt = 1; busy_ok = 1'b1;
        while (!done && cnt < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check("b2b:first_latency", cnt, 9);
        check("b2b:first_y", y, 8'h02);
        check("b2b:busy_low_fin1", busy, 0);
        a = 8'h02; b = 8'h02;
        @(negedge clk);
        cnt = 1;
        while (!done && cnt < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check("b2b:done_spacing", cnt, 9);
        check("b2b:second_y", y, 8'h04);
        check("b2b:busy_low_fin2", busy, 0);
        check("b2b:busy_high_between", busy_ok, 1);
        start = 1'b0;
        prev_y = 8'h04;
        @(negedge clk);
        check("b2b:idle_busy", busy, 0);
        check("b2b:idle_done", done, 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort:y", y, 0);
        check("abort:busy", busy, 0);
        check("abort:done", done, 0);
        check("abort:c_out", cout, 0);
        check("abort:v", v, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_y = '0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        check("abort:no_done_after", saw_done, 0);
        do_op("after_abort", 8'h33, 8'h11, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
